// File: rtl/aes_encipher_block_param_pkg.sv
// Shared AES encipher/decipher definitions: key length codes, round counts,
// FSM and update encodings, and the GF(2^8) column/row helper functions.
package aes_encipher_block_param_pkg;

    localparam logic [1:0] KEYLEN_AES128 = 2'd0;
    localparam logic [1:0] KEYLEN_AES256 = 2'd1;
    localparam logic [1:0] KEYLEN_AES192 = 2'd2;

    localparam logic [3:0] AES128_ROUNDS = 4'd10;
    localparam logic [3:0] AES192_ROUNDS = 4'd12;
    localparam logic [3:0] AES256_ROUNDS = 4'd14;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_INIT = 2'd1,
        ST_SBOX = 2'd2,
        ST_MAIN = 2'd3
    } state_e;

    typedef enum logic [2:0] {
        UPD_NONE  = 3'd0,
        UPD_INIT  = 3'd1,
        UPD_SBOX  = 3'd2,
        UPD_MAIN  = 3'd3,
        UPD_FINAL = 3'd4
    } update_e;

    // The reserved code 3 runs as AES-128.
    function automatic logic [3:0] num_rounds(input logic [1:0] kl);
        case (kl)
            KEYLEN_AES256: return AES256_ROUNDS;
            KEYLEN_AES192: return AES192_ROUNDS;
            default:       return AES128_ROUNDS;
        endcase
    endfunction

    function automatic logic [7:0] gm2(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (8'h1b & {8{b[7]}});
    endfunction

    function automatic logic [7:0] gm3(input logic [7:0] b);
        return gm2(b) ^ b;
    endfunction

    function automatic logic [31:0] mixw(input logic [31:0] w);
        logic [7:0] b0, b1, b2, b3;
        b0 = w[31:24];
        b1 = w[23:16];
        b2 = w[15:8];
        b3 = w[7:0];
        return {gm2(b0) ^ gm3(b1) ^ b2 ^ b3,
                b0 ^ gm2(b1) ^ gm3(b2) ^ b3,
                b0 ^ b1 ^ gm2(b2) ^ gm3(b3),
                gm3(b0) ^ b1 ^ b2 ^ gm2(b3)};
    endfunction

    function automatic logic [127:0] mixcolumns(input logic [127:0] s);
        return {mixw(s[127:96]), mixw(s[95:64]), mixw(s[63:32]), mixw(s[31:0])};
    endfunction

    // Words are columns, byte 3 of each word is row 0; row r rotates left by r.
    function automatic logic [127:0] shiftrows(input logic [127:0] s);
        logic [31:0] w0, w1, w2, w3;
        w0 = s[127:96];
        w1 = s[95:64];
        w2 = s[63:32];
        w3 = s[31:0];
        return {w0[31:24], w1[23:16], w2[15:8], w3[7:0],
                w1[31:24], w2[23:16], w3[15:8], w0[7:0],
                w2[31:24], w3[23:16], w0[15:8], w1[7:0],
                w3[31:24], w0[23:16], w1[15:8], w2[7:0]};
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box applied to the four bytes of one 32-bit word.
module aes_sbox (
    input  logic [31:0] sboxw_i,
    output logic [31:0] new_sboxw_o
);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign new_sboxw_o = {SBOX[sboxw_i[31:24]], SBOX[sboxw_i[23:16]],
                          SBOX[sboxw_i[15:8]],  SBOX[sboxw_i[7:0]]};

endmodule

// File: rtl/aes_encipher_block_param.sv
// Iterative AES encipher round datapath; SubBytes is spread over 4/SBOX_WORDS
// cycles through SBOX_WORDS S-box lanes, round keys are fetched by `round`.
module aes_encipher_block_param
    import aes_encipher_block_param_pkg::*;
#(
    parameter int SBOX_WORDS = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         next,
    input  logic [1:0]   keylen,
    output logic [3:0]   round,
    input  logic [127:0] round_key,
    input  logic [127:0] block,
    output logic [127:0] new_block,
    output logic         ready,
    output logic         valid
);

    localparam int         NUM_GRPS = 4 / SBOX_WORDS;
    localparam logic [1:0] LAST_GRP = 2'(NUM_GRPS - 1);

    if (!(SBOX_WORDS == 1 || SBOX_WORDS == 2 || SBOX_WORDS == 4)) begin : g_bad_sbox_words
        $fatal(1, "aes_encipher_block_param: SBOX_WORDS must be 1, 2 or 4");
    end

    state_e       state_q;
    logic [1:0]   grp_q;
    logic [3:0]   round_q;
    logic [1:0]   keylen_q;
    logic [127:0] block_q, block_d;
    logic         ready_q, valid_q;
    update_e      upd;
    logic [3:0]   nr;

    logic [31:0]  st_w     [4];
    logic [31:0]  sub_w    [4];
    logic [31:0]  sbox_in  [SBOX_WORDS];
    logic [31:0]  sbox_out [SBOX_WORDS];
    logic [1:0]   lane_idx [SBOX_WORDS];

    assign nr = num_rounds(keylen_q);

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            st_w[i] = block_q[127 - 32*i -: 32];
        end
    end

    // Lane l of group g substitutes word g*SBOX_WORDS + l.
    for (genvar l = 0; l < SBOX_WORDS; l++) begin : g_lane
        assign lane_idx[l] = 2'(32'(grp_q) * SBOX_WORDS + l);
        assign sbox_in[l]  = st_w[lane_idx[l]];
        aes_sbox u_sbox (
            .sboxw_i     (sbox_in[l]),
            .new_sboxw_o (sbox_out[l])
        );
    end

    always_comb begin
        sub_w = st_w;
        for (int l = 0; l < SBOX_WORDS; l++) begin
            sub_w[lane_idx[l]] = sbox_out[l];
        end
    end

    always_comb begin
        upd     = UPD_NONE;
        block_d = block_q;
        case (state_q)
            ST_INIT: upd = UPD_INIT;
            ST_SBOX: upd = UPD_SBOX;
            ST_MAIN: upd = (round_q < nr) ? UPD_MAIN : UPD_FINAL;
            default: upd = UPD_NONE;
        endcase
        case (upd)
            UPD_INIT:  block_d = block ^ round_key;
            UPD_SBOX:  block_d = {sub_w[0], sub_w[1], sub_w[2], sub_w[3]};
            UPD_MAIN:  block_d = mixcolumns(shiftrows(block_q)) ^ round_key;
            UPD_FINAL: block_d = shiftrows(block_q) ^ round_key;
            default:   block_d = block_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            grp_q    <= 2'd0;
            round_q  <= 4'd0;
            keylen_q <= 2'd0;
            block_q  <= 128'd0;
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
        end else begin
            block_q <= block_d;
            valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (next) begin
                        round_q  <= 4'd0;
                        ready_q  <= 1'b0;
                        keylen_q <= keylen;
                        state_q  <= ST_INIT;
                    end
                end
                ST_INIT: begin
                    round_q <= 4'd1;
                    grp_q   <= 2'd0;
                    state_q <= ST_SBOX;
                end
                ST_SBOX: begin
                    if (grp_q == LAST_GRP) begin
                        grp_q   <= 2'd0;
                        state_q <= ST_MAIN;
                    end else begin
                        grp_q <= grp_q + 2'd1;
                    end
                end
                ST_MAIN: begin
                    if (upd == UPD_MAIN) begin
                        round_q <= round_q + 4'd1;
                        state_q <= ST_SBOX;
                    end else begin
                        ready_q <= 1'b1;
                        valid_q <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign round     = round_q;
    assign new_block = block_q;
    assign ready     = ready_q;
    assign valid     = valid_q;

endmodule
